// File: rtl/note_glyph_engine.sv
// note_glyph_engine: glyph bitmap table plus a renderer that streams one glyph
// as a pixel-per-handshake stream with optional mirror and invert.
module note_glyph_engine #(
   parameter int GLYPH_W = 8,
   parameter int GLYPH_H = 8,
   parameter int CODE_W  = 5
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       wr_en,
   input  logic [CODE_W-1:0]          wr_code,
   input  logic [$clog2(GLYPH_H)-1:0] wr_row,
   input  logic [GLYPH_W-1:0]         wr_data,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [CODE_W-1:0]          req_code,
   input  logic                       req_hflip,
   input  logic                       req_vflip,
   input  logic                       req_invert,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_pixel,
   output logic [$clog2(GLYPH_W)-1:0] out_x,
   output logic [$clog2(GLYPH_H)-1:0] out_y,
   output logic                       out_last,
   output logic                       done
);
   localparam int XW = $clog2(GLYPH_W);
   localparam int YW = $clog2(GLYPH_H);
   localparam logic [XW-1:0] X_MAX = XW'(GLYPH_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(GLYPH_H - 1);
   typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;
   state_t             state_q;
   logic [GLYPH_W-1:0] mem_q [2**CODE_W][GLYPH_H] = '{default: '0};
   logic [CODE_W-1:0]  code_q;
   logic               hflip_q, vflip_q, invert_q, done_q;
   logic [XW-1:0]      x_q;
   logic [YW-1:0]      y_q;
   logic [GLYPH_W-1:0] row_q;
   logic [YW-1:0]      rd_row;
   logic [XW-1:0]      bit_idx;
   logic               emit, at_last;
   // Table is never touched by Reset so glyphs survive an aborted render.
   always_ff @(posedge Clk)
      if (wr_en) mem_q[wr_code][wr_row] <= wr_data;
   always_comb begin
      rd_row  = vflip_q ? Y_MAX - y_q : y_q;
      bit_idx = hflip_q ? x_q : X_MAX - x_q;
      emit    = state_q == EMIT;
      at_last = x_q == X_MAX && y_q == Y_MAX;
   end
   assign req_ready = state_q == IDLE;
   assign out_valid = emit;
   assign out_pixel = emit & (row_q[bit_idx] ^ invert_q);
   assign out_x     = x_q;
   assign out_y     = y_q;
   assign out_last  = emit & at_last;
   assign done      = done_q;
   // Row read is registered; a same-edge write to the entry yields the old row.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         code_q   <= '0;
         hflip_q  <= 1'b0;
         vflip_q  <= 1'b0;
         invert_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         row_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: if (req_valid) begin
               code_q   <= req_code;
               hflip_q  <= req_hflip;
               vflip_q  <= req_vflip;
               invert_q <= req_invert;
               x_q      <= '0;
               y_q      <= '0;
               state_q  <= FETCH;
            end
            FETCH: begin
               row_q   <= mem_q[code_q][rd_row];
               state_q <= EMIT;
            end
            EMIT: if (out_ready) begin
               if (x_q != X_MAX) x_q <= x_q + 1'b1;
               else if (y_q != Y_MAX) begin
                  x_q     <= '0;
                  y_q     <= y_q + 1'b1;
                  state_q <= FETCH;
               end else begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_note_glyph_engine.sv
// tb_note_glyph_engine: scoreboard bench; a visual-mirror glyph model queues
// expected pixels, an independent monitor checks every accepted pixel.
module tb_note_glyph_engine;
   logic       Clk = 0, Reset = 1, wr_en = 0, req_valid = 0;
   logic       req_hflip = 0, req_vflip = 0, req_invert = 0, out_ready = 1;
   logic [4:0] wr_code = 0, req_code = 0;
   logic [2:0] wr_row = 0;
   logic [7:0] wr_data = 0;
   logic       req_ready, out_valid, out_pixel, out_last, done;
   logic [2:0] out_x, out_y;
   int         tests = 0, fails = 0, rdy_mode = 0, rc = 0, cyc = 0;
   typedef struct packed {logic p; logic last; logic [2:0] x; logic [2:0] y;} pix_t;
   pix_t       sb[$];
   pix_t       cur, prev, e;
   logic       exp_done = 0, held = 0;
   logic [7:0] tbl [32][8];

   note_glyph_engine dut (
      .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_code(wr_code), .wr_row(wr_row),
      .wr_data(wr_data), .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
      .req_hflip(req_hflip), .req_vflip(req_vflip), .req_invert(req_invert),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .out_x(out_x), .out_y(out_y), .out_last(out_last), .done(done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected image: output (x,y) shows source pixel at mirrored coordinates;
   // source column c of a row is bit 7-c (MSB is the leftmost pixel).
   task automatic push_glyph(input int code, input bit h, input bit v, input bit inv);
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++) begin
            int   sx = h ? 7 - x : x;
            int   sy = v ? 7 - y : y;
            pix_t p;
            p.p    = tbl[code][sy][7 - sx] ^ inv;
            p.last = (x == 7 && y == 7);
            p.x    = 3'(x);
            p.y    = 3'(y);
            sb.push_back(p);
         end
   endtask

   task automatic wr(input int code, input int row, input logic [7:0] data);
      wr_en = 1; wr_code = 5'(code); wr_row = 3'(row); wr_data = data;
      tbl[code][row] = data;
      @(negedge Clk);
      wr_en = 0;
   endtask

   task automatic render(input int code, input bit h, input bit v, input bit inv,
                         input bit collide = 0, input logic [7:0] cdata = 0);
      int n = 0;
      while (!req_ready && n < 200) begin @(negedge Clk); n++; end
      chk("req_ready before request", 32'(req_ready), 1);
      req_code = 5'(code); req_hflip = h; req_vflip = v; req_invert = inv; req_valid = 1;
      push_glyph(code, h, v, inv);
      @(negedge Clk);
      req_valid = 0;
      req_code = 5'($urandom); req_hflip = 1'($urandom); req_vflip = 1'($urandom);
      req_invert = 1'($urandom);
      chk("fetch cycle out_valid", 32'(out_valid), 0);
      chk("req_ready busy", 32'(req_ready), 0);
      if (collide) begin
         wr_en = 1; wr_code = 5'(code); wr_row = v ? 3'd7 : 3'd0; wr_data = cdata;
      end
      @(negedge Clk);
      if (collide) begin wr_en = 0; tbl[code][v ? 7 : 0] = cdata; end
      chk("first pixel latency", 32'(out_valid), 1);
   endtask

   task automatic wait_done(output int c);
      c = 0;
      while (!done && c < 3000) begin @(negedge Clk); c++; end
      chk("done seen before timeout", 32'(done), 1);
   endtask

   task automatic wait_at(input int x, input int y);
      int n = 0;
      while (!(out_valid && out_x == 3'(x) && out_y == 3'(y)) && n < 500) begin
         @(negedge Clk); n++;
      end
      chk("reached pixel", {out_valid, 5'd0, out_x, 5'd0, out_y}, {1'b1, 5'd0, 3'(x), 5'd0, 3'(y)});
   endtask

   initial forever begin
      @(posedge Clk); #1;
      rc++;
      out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (rc % 4 == 0 || rc % 4 == 3) : 1'($urandom);
   end

   // Monitor: samples 1 time unit after each falling edge.
   initial forever begin
      @(negedge Clk); #1;
      if (Reset) begin
         exp_done = 0; held = 0;
      end else begin
         chk("done pulse", 32'(done), 32'(exp_done));
         cur.p = out_pixel; cur.last = out_last; cur.x = out_x; cur.y = out_y;
         if (held) chk("held through stall", {out_valid, cur}, {1'b1, prev});
         exp_done = 0;
         held = out_valid && !out_ready;
         prev = cur;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected pixel: got x=%0d y=%0d expected none", out_x, out_y);
            end else begin
               e = sb.pop_front();
               chk("pixel", 32'(cur), 32'(e));
               exp_done = e.last;
            end
         end
      end
   end

   initial begin
      for (int c = 0; c < 32; c++) for (int r = 0; r < 8; r++) tbl[c][r] = 8'h00;
      repeat (2) @(negedge Clk);
      chk("reset out_valid", 32'(out_valid), 0);
      chk("reset outs", {out_last, done, out_pixel, out_x, out_y}, 0);
      Reset = 0;
      @(negedge Clk);
      chk("reset req_ready", 32'(req_ready), 1);
      // Plain render with exact timing: 64 pixels + 7 bubbles before done.
      wr(1, 0, 8'h00); wr(1, 1, 8'h18); wr(1, 2, 8'h7E); wr(1, 3, 8'hFF);
      wr(1, 4, 8'hFF); wr(1, 5, 8'h7E); wr(1, 6, 8'h18); wr(1, 7, 8'h00);
      render(1, 0, 0, 0);
      wait_done(cyc);
      chk("glyph cycles first pixel to done", 32'(cyc), 71);
      // Mirror modes.
      for (int r = 0; r < 8; r++) wr(3, r, 8'(8'h10 + r));
      wr(3, 0, 8'h07); wr(3, 7, 8'hC1);
      render(3, 1, 0, 0); wait_done(cyc);
      render(3, 0, 1, 0); wait_done(cyc);
      render(3, 1, 1, 1); wait_done(cyc);
      // Invert of empty glyph.
      render(0, 0, 0, 1); wait_done(cyc);
      // Back-pressure pattern.
      rdy_mode = 1;
      render(1, 0, 0, 0); wait_done(cyc);
      rdy_mode = 0;
      // Mid-render write affects only the later row.
      tbl[1][5] = 8'h00;
      render(1, 0, 0, 0);
      wait_at(0, 2);
      wr(1, 5, 8'h00);
      wait_done(cyc);
      // Same-entry write during the fetch returns the old row.
      wr(5, 0, 8'hA5);
      render(5, 0, 0, 0, 1, 8'h3C); wait_done(cyc);
      render(5, 0, 0, 0); wait_done(cyc);
      // Reset mid-glyph aborts without done; table survives.
      render(1, 0, 0, 0);
      wait_at(3, 4);
      Reset = 1;
      @(negedge Clk);
      Reset = 0;
      sb.delete();
      chk("abort out_valid", 32'(out_valid), 0);
      chk("abort req_ready", 32'(req_ready), 1);
      chk("abort xy", {out_x, out_y}, 0);
      repeat (5) @(negedge Clk);
      render(1, 0, 0, 0); wait_done(cyc);
      // Randomized traffic.
      rdy_mode = 2;
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(1, 4)) wr($urandom_range(0, 31), $urandom_range(0, 7), 8'($urandom));
         render($urandom_range(0, 31), 1'($urandom), 1'($urandom), 1'($urandom));
         wait_done(cyc);
      end
      repeat (3) @(negedge Clk);
      chk("scoreboard drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/note_glyph_engine.md
NOTE_GLYPH_ENGINE -- requirements
Module: note_glyph_engine

Interface
REQ-001 SHALL provide parameter GLYPH_W, default 8, meaning pixels per glyph row.
REQ-002 SHALL provide parameter GLYPH_H, default 8, meaning rows per glyph.
REQ-003 SHALL provide parameter CODE_W, default 5, meaning glyph code width; the table holds 2**CODE_W glyphs.
REQ-004 SHALL have one clock and a synchronous, active-high reset: Clk  in  1  rising-edge clock; Reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports:
- wr_en  in  1  table write strobe
- wr_code  in  CODE_W  glyph to write
- wr_row  in  clog2(GLYPH_H)  row to write
- wr_data  in  GLYPH_W  row bits, MSB = leftmost pixel
- req_valid  in  1  render request
- req_ready  out  1  engine can accept a request
- req_code  in  CODE_W  glyph to render
- req_hflip  in  1  mirror left-right
- req_vflip  in  1  mirror top-bottom
- req_invert  in  1  invert pixels
- out_valid  out  1  pixel valid
- out_ready  in  1  sink accepts pixel
- out_pixel  out  1  pixel value
- out_x  out  clog2(GLYPH_W)  pixel column
- out_y  out  clog2(GLYPH_H)  pixel row
- out_last  out  1  final pixel of glyph
- done  out  1  one-cycle pulse after final pixel is accepted

Function
REQ-006 SHALL hold a glyph table of 2**CODE_W x GLYPH_H rows of GLYPH_W bits, zero-initialised, with one write port and one registered read port.
REQ-007 SHALL write wr_data to (wr_code, wr_row) on any Clk edge with wr_en=1, in any state.
REQ-008 SHALL return the pre-write data when a read and a write hit the same entry in the same cycle.
REQ-009 SHALL implement states IDLE, FETCH and EMIT.
REQ-010 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-011 SHALL latch req_code, req_hflip, req_vflip and req_invert on acceptance, clear the row and column counters, and enter FETCH.
REQ-012 In FETCH (one cycle), SHALL read table row r, where r = vflip ? GLYPH_H-1-y : y, load it into the row register, and enter EMIT.
REQ-013 In EMIT, SHALL drive out_valid=1 and out_pixel = row bit (hflip ? x : GLYPH_W-1-x) XOR invert, with out_x = x and out_y = y.
REQ-014 SHALL hold out_valid, out_pixel, out_x, out_y and out_last stable while out_valid=1 and out_ready=0.
REQ-015 On an EMIT handshake with x < GLYPH_W-1, SHALL increment x.
REQ-016 On an EMIT handshake with x = GLYPH_W-1 and y < GLYPH_H-1, SHALL clear x, increment y and return to FETCH, giving one bubble cycle per row.
REQ-017 SHALL drive out_last=1 only when x = GLYPH_W-1 and y = GLYPH_H-1.
REQ-018 On the out_last handshake, SHALL enter IDLE and pulse done=1 in the following cycle.
REQ-019 SHALL produce first-pixel latency of two cycles: for a request accepted at edge k, out_valid=1 in the cycle after edge k+1.
REQ-020 SHALL give each glyph exactly GLYPH_W*GLYPH_H handshakes, with x and y never wrapping mid-glyph.
REQ-021 Table writes during rendering SHALL affect only rows fetched after the write edge; the latched row register is unaffected.
REQ-022 SHALL ignore request inputs that change outside an accepting handshake.

Reset
REQ-023 With Reset=1 at an edge, SHALL enter IDLE, clear x, y and the latched flags, and drive out_valid=0, out_last=0, done=0, out_pixel=0, out_x=0, out_y=0; req_ready=1 from the next cycle.
REQ-024 Reset SHALL NOT alter glyph table contents.
REQ-025 Reset in mid-glyph SHALL abort the glyph with no done pulse.

Verification
REQ-026 Bench SHALL cover these directed scenarios:
- Write code 1 with rows 00,18,7E,FF,FF,7E,18,00 (hex), render with no flags, out_ready=1 -> row 1 pixels 0,0,0,1,1,0,0,0; 64 pixels plus 7 bubbles; done 1 cycle after out_last.
- Code 3 row 0 = 07, hflip=1 -> row 0 pixels 1,1,1,0,0,0,0,0; vflip=1 -> out_y=0 shows table row 7.
- invert=1 on code 0 (all zero) -> 64 ones.
- out_ready toggling 1,0,0,1 -> each pixel held through stall; no pixel lost or duplicated; x and y sequence intact.
- Write code 1 row 5 = 00 while row 2 is emitting -> out_y=5 emits zeros; rows 0-4 unchanged; same-entry write/read collision in FETCH -> old data emitted.
- Reset at x=3, y=4 -> out_valid=0 next cycle, no done pulse, req_ready=1; re-render shows table contents preserved.
